// File: rtl/mu_rst_pkg.sv
// Shared state encoding and width helper for the reset sequencer.
package mu_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } rst_state_e;

  // Counter width for a given terminal value, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/mu_drsync.sv
// Two-flop synchronizer with asynchronous active-low clear; used for both
// reset-release synchronization and lock-indication synchronization.
module mu_drsync (
  input  logic clk,
  input  logic nreset,
  input  logic in,
  output logic out
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
    end
  end

  assign out = s2_q;

endmodule

// File: rtl/mu_rst_seq.sv
// Reset sequencer: filters PLL lock, then releases nrst_out bits one at a time
// with HOLD_CYCLES spacing; lock loss or sw_rst re-asserts everything.
module mu_rst_seq
  import mu_rst_pkg::*;
#(
  parameter int N_OUT       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int LOCK_FILTER = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             lock_async,
  input  logic             sw_rst,
  output logic [N_OUT-1:0] nrst_out,
  output logic             ready,
  output logic [1:0]       state_o
);

  localparam int HOLD_W = clog2_min1(HOLD_CYCLES);
  localparam int FILT_W = clog2_min1(LOCK_FILTER + 1);
  localparam int IDX_W  = clog2_min1(N_OUT);

  logic rst_n_s;
  logic lock_s;

  mu_drsync u_rst_sync (
    .clk    (clk),
    .nreset (nreset),
    .in     (1'b1),
    .out    (rst_n_s)
  );

  mu_drsync u_lock_sync (
    .clk    (clk),
    .nreset (rst_n_s),
    .in     (lock_async),
    .out    (lock_s)
  );

  rst_state_e        state_q;
  logic [N_OUT-1:0]  nrst_out_q;
  logic              ready_q;
  logic [HOLD_W-1:0] hold_q;
  logic [FILT_W-1:0] filt_q;
  logic [IDX_W-1:0]  idx_q;

  logic fault;
  logic hold_last;
  logic filt_last;
  logic idx_last;

  assign fault     = !lock_s || sw_rst;
  assign hold_last = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  assign filt_last = (filt_q == FILT_W'(LOCK_FILTER - 1));
  assign idx_last  = (idx_q == IDX_W'(N_OUT - 1));

  // A fault always beats a release scheduled on the same edge.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q    <= WAIT_LOCK;
      nrst_out_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!sw_rst && lock_s && filt_last) state_q <= RELEASE;
        end
        RELEASE: begin
          if (fault) begin
            state_q    <= HOLD;
            nrst_out_q <= '0;
            ready_q    <= 1'b0;
          end else if (hold_last) begin
            nrst_out_q[idx_q] <= 1'b1;
            if (idx_last) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fault) begin
            state_q    <= HOLD;
            nrst_out_q <= '0;
            ready_q    <= 1'b0;
          end
        end
        HOLD: begin
          if (!sw_rst && hold_last) state_q <= WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      hold_q <= '0;
      filt_q <= '0;
      idx_q  <= '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          hold_q <= '0;
          idx_q  <= '0;
          if (sw_rst || !lock_s || filt_last) filt_q <= '0;
          else                                filt_q <= filt_q + FILT_W'(1);
        end
        RELEASE: begin
          filt_q <= '0;
          if (fault) begin
            hold_q <= '0;
            idx_q  <= '0;
          end else if (hold_last) begin
            hold_q <= '0;
            idx_q  <= idx_last ? '0 : idx_q + IDX_W'(1);
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        RUN: begin
          hold_q <= '0;
          filt_q <= '0;
          idx_q  <= '0;
        end
        HOLD: begin
          filt_q <= '0;
          idx_q  <= '0;
          // sw_rst restarts the hold window so it lasts HOLD_CYCLES after the last request.
          if (sw_rst || hold_last) hold_q <= '0;
          else                     hold_q <= hold_q + HOLD_W'(1);
        end
      endcase
    end
  end

  assign nrst_out = nrst_out_q;
  assign ready    = ready_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_mu_rst_seq.sv
// Directed bench for mu_rst_seq with default parameters.
module tb_mu_rst_seq;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       nreset = 1'b0;
  logic       lock_async = 1'b0;
  logic       sw_rst = 1'b0;
  logic [3:0] nrst_out;
  logic       ready;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  bit mon_en = 1'b0;

  mu_rst_seq #(.N_OUT(4), .HOLD_CYCLES(16), .LOCK_FILTER(8)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .lock_async (lock_async),
    .sw_rst     (sw_rst),
    .nrst_out   (nrst_out),
    .ready      (ready),
    .state_o    (state_o)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Output invariants checked on every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (ready !== (&nrst_out)) begin n_err++; $display("FAIL mon_ready_and: ready=%b nrst_out=%b", ready, nrst_out); end
      n_cmp++;
      if ((({1'b0, nrst_out} + 5'd1) & {1'b0, nrst_out}) !== 5'd0) begin n_err++; $display("FAIL mon_thermometer: nrst_out=%b want thermometer code", nrst_out); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic bring_up;
    nreset = 1'b0; lock_async = 1'b0; sw_rst = 1'b0;
    tick(2);
    nreset = 1'b1;
    tick(2);
    lock_async = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    tick(3);
    n_cmp++; if (nrst_out !== 4'b0000) begin n_err++; $display("FAIL reset_nrst_out: got %b want 0000", nrst_out); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    mon_en = 1'b1;
  endtask

  task automatic test_power_up;
    bring_up();
    step_to(9);  n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL pu_state_e9: got %0d want 0", state_o); end
    step_to(10); n_cmp++; if (state_o !== 2'd1) begin n_err++; $display("FAIL pu_state_e10: got %0d want 1", state_o); end
    step_to(25); n_cmp++; if (nrst_out !== 4'b0000) begin n_err++; $display("FAIL pu_nrst_e25: got %b want 0000", nrst_out); end
    step_to(26); n_cmp++; if (nrst_out !== 4'b0001) begin n_err++; $display("FAIL pu_nrst_e26: got %b want 0001", nrst_out); end
    step_to(41); n_cmp++; if (nrst_out !== 4'b0001) begin n_err++; $display("FAIL pu_nrst_e41: got %b want 0001", nrst_out); end
    step_to(42); n_cmp++; if (nrst_out !== 4'b0011) begin n_err++; $display("FAIL pu_nrst_e42: got %b want 0011", nrst_out); end
    step_to(58); n_cmp++; if (nrst_out !== 4'b0111) begin n_err++; $display("FAIL pu_nrst_e58: got %b want 0111", nrst_out); end
    step_to(73); n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL pu_ready_e73: got %b want 0", ready); end
    step_to(74); n_cmp++; if (nrst_out !== 4'b1111) begin n_err++; $display("FAIL pu_nrst_e74: got %b want 1111", nrst_out); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL pu_ready_e74: got %b want 1", ready); end
    n_cmp++; if (state_o !== 2'd2) begin n_err++; $display("FAIL pu_state_e74: got %0d want 2", state_o); end
    step_to(90); n_cmp++; if (nrst_out !== 4'b1111 || state_o !== 2'd2) begin n_err++; $display("FAIL pu_run_hold: nrst_out=%b state=%0d want 1111/2", nrst_out, state_o); end
  endtask

  task automatic test_lock_loss;
    lock_async = 1'b0;
    edge_n = 0;
    step_to(2);  n_cmp++; if (nrst_out !== 4'b1111) begin n_err++; $display("FAIL ll_nrst_e2: got %b want 1111", nrst_out); end
    step_to(3);  n_cmp++; if (nrst_out !== 4'b0000 || ready !== 1'b0) begin n_err++; $display("FAIL ll_assert_e3: nrst_out=%b ready=%b want 0000/0", nrst_out, ready); end
    n_cmp++; if (state_o !== 2'd3) begin n_err++; $display("FAIL ll_state_e3: got %0d want 3", state_o); end
    step_to(18); n_cmp++; if (state_o !== 2'd3) begin n_err++; $display("FAIL ll_hold_e18: got %0d want 3", state_o); end
    step_to(19); n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL ll_exit_e19: got %0d want 0", state_o); end
    lock_async = 1'b1;
    edge_n = 0;
    step_to(9);  n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL ll_relock_e9: got %0d want 0", state_o); end
    step_to(10); n_cmp++; if (state_o !== 2'd1) begin n_err++; $display("FAIL ll_relock_e10: got %0d want 1", state_o); end
    step_to(26); n_cmp++; if (nrst_out !== 4'b0001) begin n_err++; $display("FAIL ll_relock_e26: got %b want 0001", nrst_out); end
    step_to(74); n_cmp++; if (nrst_out !== 4'b1111 || ready !== 1'b1) begin n_err++; $display("FAIL ll_relock_e74: nrst_out=%b ready=%b want 1111/1", nrst_out, ready); end
  endtask

  task automatic test_lock_glitch;
    nreset = 1'b0; lock_async = 1'b0;
    tick(2);
    nreset = 1'b1;
    tick(2);
    lock_async = 1'b1;
    tick(5);
    lock_async = 1'b0;
    tick(10);
    n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL gl_state: got %0d want 0", state_o); end
    tick(10);
    n_cmp++; if (nrst_out !== 4'b0000) begin n_err++; $display("FAIL gl_nrst: got %b want 0000", nrst_out); end
    lock_async = 1'b1;
    edge_n = 0;
    step_to(9);  n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL gl_recount_e9: got %0d want 0", state_o); end
    step_to(10); n_cmp++; if (state_o !== 2'd1) begin n_err++; $display("FAIL gl_recount_e10: got %0d want 1", state_o); end
  endtask

  task automatic test_wait_lock_sw_rst;
    bring_up();
    step_to(7);
    sw_rst = 1'b1;
    step_to(8);
    sw_rst = 1'b0;
    step_to(10); n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL wl_sw_e10: got %0d want 0", state_o); end
    step_to(15); n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL wl_sw_e15: got %0d want 0", state_o); end
    step_to(16); n_cmp++; if (state_o !== 2'd1) begin n_err++; $display("FAIL wl_sw_e16: got %0d want 1", state_o); end
  endtask

  task automatic test_sw_rst_hold;
    bring_up();
    step_to(42); n_cmp++; if (nrst_out !== 4'b0011) begin n_err++; $display("FAIL sw_pre_e42: got %b want 0011", nrst_out); end
    sw_rst = 1'b1;
    step_to(43);
    sw_rst = 1'b0;
    n_cmp++; if (nrst_out !== 4'b0000 || state_o !== 2'd3) begin n_err++; $display("FAIL sw_assert_e43: nrst_out=%b state=%0d want 0000/3", nrst_out, state_o); end
    step_to(53);
    sw_rst = 1'b1;
    step_to(54);
    sw_rst = 1'b0;
    step_to(60); n_cmp++; if (state_o !== 2'd3) begin n_err++; $display("FAIL sw_extend_e60: got %0d want 3", state_o); end
    step_to(69); n_cmp++; if (state_o !== 2'd3) begin n_err++; $display("FAIL sw_extend_e69: got %0d want 3", state_o); end
    step_to(70); n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL sw_exit_e70: got %0d want 0", state_o); end
    step_to(77); n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL sw_refilt_e77: got %0d want 0", state_o); end
    step_to(78); n_cmp++; if (state_o !== 2'd1) begin n_err++; $display("FAIL sw_refilt_e78: got %0d want 1", state_o); end
  endtask

  task automatic test_fault_on_release;
    bring_up();
    step_to(57); n_cmp++; if (nrst_out !== 4'b0011) begin n_err++; $display("FAIL fr_pre_e57: got %b want 0011", nrst_out); end
    sw_rst = 1'b1;
    step_to(58);
    sw_rst = 1'b0;
    n_cmp++; if (nrst_out !== 4'b0000 || state_o !== 2'd3) begin n_err++; $display("FAIL fr_e58: nrst_out=%b state=%0d want 0000/3", nrst_out, state_o); end
    step_to(63); n_cmp++; if (nrst_out !== 4'b0000) begin n_err++; $display("FAIL fr_e63: got %b want 0000", nrst_out); end
  endtask

  task automatic test_async_reset;
    bring_up();
    step_to(60); n_cmp++; if (nrst_out !== 4'b0111 || state_o !== 2'd1) begin n_err++; $display("FAIL ar_pre_e60: nrst_out=%b state=%0d want 0111/1", nrst_out, state_o); end
    @(negedge clk);
    clk_en = 1'b0;
    #7;
    nreset = 1'b0;
    #1;
    n_cmp++; if (nrst_out !== 4'b0000 || ready !== 1'b0) begin n_err++; $display("FAIL ar_async_clear: nrst_out=%b ready=%b want 0000/0", nrst_out, ready); end
    n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL ar_async_state: got %0d want 0", state_o); end
    #10;
    nreset = 1'b1;
    clk_en = 1'b1;
    edge_n = 0;
    step_to(11); n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL ar_sync_e11: got %0d want 0", state_o); end
    step_to(12); n_cmp++; if (state_o !== 2'd1) begin n_err++; $display("FAIL ar_sync_e12: got %0d want 1", state_o); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss();
    test_lock_glitch();
    test_wait_lock_sw_rst();
    test_sw_rst_hold();
    test_fault_on_release();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
